// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_checker
// Purpose  : Self-synchronising LFSR sequence checker; flywheels after lock
//            and reports mismatches as pulses plus a saturating count.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int                      OUTPUT_WIDTH = 4,
    parameter logic [OUTPUT_WIDTH-1:0] TAPS         = 4'b1100,
    parameter int                      LOCK_COUNT   = 3,
    parameter int                      ERR_LIMIT    = 2,
    parameter int                      CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enb,
    input  logic [OUTPUT_WIDTH-1:0] data_in,
    input  logic                    clr_cnt,
    output logic                    locked,
    output logic                    err,
    output logic [CNT_WIDTH-1:0]    err_count
);

    localparam int c_GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int c_BAD_W  = $clog2(ERR_LIMIT + 1);
    localparam logic [c_GOOD_W-1:0] c_LOCK_CNT = c_GOOD_W'(LOCK_COUNT);
    localparam logic [c_BAD_W-1:0]  c_ERR_LIM  = c_BAD_W'(ERR_LIMIT);
    localparam logic [c_GOOD_W-1:0] c_GOOD_ONE = c_GOOD_W'(1);
    localparam logic [c_BAD_W-1:0]  c_BAD_ONE  = c_BAD_W'(1);

    localparam logic [1:0] c_SEARCH = 2'd0;
    localparam logic [1:0] c_VERIFY = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    function automatic logic [OUTPUT_WIDTH-1:0] f_next(input logic [OUTPUT_WIDTH-1:0] s);
        return {s[OUTPUT_WIDTH-2:0], ^(s & TAPS)};
    endfunction

    logic [1:0]              r_state, w_state_nxt;
    logic [OUTPUT_WIDTH-1:0] r_pred, w_pred_nxt;
    logic [c_GOOD_W-1:0]     r_good_cnt, w_good_nxt, w_good_inc;
    logic [c_BAD_W-1:0]      r_bad_cnt, w_bad_nxt, w_bad_inc;
    logic                    w_mismatch;
    logic                    r_locked, r_err;
    logic [CNT_WIDTH-1:0]    r_err_count;

    assign w_good_inc = r_good_cnt + c_GOOD_ONE;
    assign w_bad_inc  = r_bad_cnt + c_BAD_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_pred_nxt  = r_pred;
        w_good_nxt  = r_good_cnt;
        w_bad_nxt   = r_bad_cnt;
        w_mismatch  = 1'b0;
        if (enb) begin
            case (r_state)
                c_SEARCH: begin
                    // All-zero is the LFSR lock-up word and can never seed a chain
                    if (data_in != '0) begin
                        w_pred_nxt  = f_next(data_in);
                        w_good_nxt  = c_GOOD_ONE;
                        w_state_nxt = c_VERIFY;
                    end
                end
                c_VERIFY: begin
                    if (data_in == r_pred) begin
                        w_pred_nxt = f_next(data_in);
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == c_LOCK_CNT) begin
                            w_state_nxt = c_LOCKED;
                            w_bad_nxt   = '0;
                        end
                    end else if (data_in != '0) begin
                        w_pred_nxt = f_next(data_in);
                        w_good_nxt = c_GOOD_ONE;
                    end else begin
                        w_state_nxt = c_SEARCH;
                    end
                end
                c_LOCKED: begin
                    // Flywheel: prediction advances from itself, never from data_in
                    w_pred_nxt = f_next(r_pred);
                    if (data_in == r_pred) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_mismatch = 1'b1;
                        if (w_bad_inc == c_ERR_LIM) begin
                            w_state_nxt = c_SEARCH;
                            w_bad_nxt   = '0;
                        end else begin
                            w_bad_nxt = w_bad_inc;
                        end
                    end
                end
                default: w_state_nxt = c_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_SEARCH;
            r_pred      <= '0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pred     <= w_pred_nxt;
            r_good_cnt <= w_good_nxt;
            r_bad_cnt  <= w_bad_nxt;
            r_locked   <= (w_state_nxt == c_LOCKED);
            r_err      <= w_mismatch;
            // Clear wins over a same-cycle increment
            if (clr_cnt) begin
                r_err_count <= '0;
            end else if (w_mismatch && (r_err_count != '1)) begin
                r_err_count <= r_err_count + CNT_WIDTH'(1);
            end
        end
    end

    assign locked    = r_locked;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_checker
// Purpose  : Directed plus randomized check of lfsr_checker against a
//            sample-level behavioural model (16-bit and 2-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

    localparam logic [3:0] c_TAPS  = 4'b1100;
    localparam int         c_LOCK  = 3;
    localparam int         c_ELIM  = 2;
    localparam int         c_MAX16 = 65535;
    localparam int         c_MAX2  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic [3:0]  data_in;
    logic        clr_cnt;
    logic        locked, err, locked_s, err_s;
    logic [15:0] err_count;
    logic [1:0]  err_count_s;

    always #5 clk = ~clk;

    lfsr_checker #(.OUTPUT_WIDTH(4), .TAPS(c_TAPS), .LOCK_COUNT(c_LOCK),
                   .ERR_LIMIT(c_ELIM), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enb(enb), .data_in(data_in), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_count(err_count));

    lfsr_checker #(.OUTPUT_WIDTH(4), .TAPS(c_TAPS), .LOCK_COUNT(c_LOCK),
                   .ERR_LIMIT(c_ELIM), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .enb(enb), .data_in(data_in), .clr_cnt(clr_cnt),
        .locked(locked_s), .err(err_s), .err_count(err_count_s));

    int checks   = 0;
    int failures = 0;

    // Model: run length of a valid chain while hunting, flywheel word once locked
    bit         m_locked, m_err;
    int         m_run, m_miss, m_cnt, m_cnt_s;
    logic [3:0] m_last, m_pred;
    logic [3:0] g;

    function automatic logic [3:0] lfsr_next(input logic [3:0] s);
        int p = 0;
        for (int i = 0; i < 4; i++)
            if (c_TAPS[i] && s[i]) p = p ^ 1;
        return {s[2:0], p[0]};
    endfunction

    task automatic model_reset();
        m_locked = 0; m_err = 0; m_run = 0; m_miss = 0;
        m_cnt = 0; m_cnt_s = 0; m_last = '0; m_pred = '0;
    endtask

    task automatic model_sample(input logic e, input logic [3:0] d, input logic c);
        bit mis = 0;
        if (e) begin
            if (m_locked) begin
                if (d !== m_pred) begin
                    mis = 1;
                    m_miss++;
                    if (m_miss == c_ELIM) begin
                        m_locked = 0; m_miss = 0; m_run = 0;
                    end
                end else begin
                    m_miss = 0;
                end
                m_pred = lfsr_next(m_pred);
            end else begin
                if (d == 4'd0) m_run = 0;
                else if (m_run > 0 && d == lfsr_next(m_last)) m_run++;
                else m_run = 1;
                m_last = d;
                if (m_run == c_LOCK) begin
                    m_locked = 1; m_miss = 0; m_pred = lfsr_next(d);
                end
            end
        end
        m_err = mis;
        if (c) begin
            m_cnt = 0; m_cnt_s = 0;
        end else if (mis) begin
            if (m_cnt < c_MAX16) m_cnt++;
            if (m_cnt_s < c_MAX2) m_cnt_s++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"},   32'(locked),      32'(m_locked));
        chk({tag, ".err"},      32'(err),         32'(m_err));
        chk({tag, ".count"},    32'(err_count),   32'(m_cnt));
        chk({tag, ".locked_s"}, 32'(locked_s),    32'(m_locked));
        chk({tag, ".err_s"},    32'(err_s),       32'(m_err));
        chk({tag, ".count_s"},  32'(err_count_s), 32'(m_cnt_s));
    endtask

    task automatic step(input logic e, input logic [3:0] d, input logic c, input string tag);
        @(negedge clk);
        enb = e; data_in = d; clr_cnt = c;
        @(posedge clk);
        model_sample(e, d, c);
        #1 check_all(tag);
    endtask

    task automatic send_gen(input string tag);
        step(1'b1, g, 1'b0, tag);
        g = lfsr_next(g);
    endtask

    task automatic send_bad(input logic [3:0] mask, input logic c, input string tag);
        step(1'b1, g ^ mask, c, tag);
        g = lfsr_next(g);
    endtask

    // Reset asserted between edges; outputs must clear without a clock
    task automatic do_reset(input string tag);
        @(negedge clk);
        enb = 1'b0; clr_cnt = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk({tag, ".locked"}, 32'(locked), 32'd0);
        chk({tag, ".err"},    32'(err),    32'd0);
        chk({tag, ".count"},  32'(err_count), 32'd0);
        #1 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; enb = 1'b0; data_in = '0; clr_cnt = 1'b0;
        model_reset();
        g = 4'b0100;
        #12;
        chk("reset.locked", 32'(locked), 32'd0);
        chk("reset.count",  32'(err_count), 32'd0);
        rst = 1'b1;

        repeat (3) step(1'b0, 4'($urandom_range(0, 15)), 1'b0, "idle");

        // Clean lock from seed 0100
        g = 4'b0100;
        send_gen("lock1"); send_gen("lock2");
        chk("lock.before_third", 32'(locked), 32'd0);
        send_gen("lock3");
        chk("lock.after_third", 32'(locked), 32'd1);

        // Single error where 0110 is expected, then 1101 still matches
        chk("flywheel.expect_0110", 32'(g), 32'(4'b0110));
        step(1'b1, 4'b0000, 1'b0, "single_err");
        g = lfsr_next(g);
        chk("single_err.err", 32'(err), 32'd1);
        chk("single_err.count", 32'(err_count), 32'd1);
        chk("single_err.locked", 32'(locked), 32'd1);
        send_gen("flywheel_1101");
        chk("flywheel.err", 32'(err), 32'd0);

        // Two consecutive wrong words drop lock
        send_bad(4'b0011, 1'b0, "loss1");
        chk("loss1.locked", 32'(locked), 32'd1);
        send_bad(4'b0101, 1'b0, "loss2");
        chk("loss2.locked", 32'(locked), 32'd0);
        chk("loss2.count", 32'(err_count), 32'd3);

        // Relock, then reset mid-lock
        g = 4'b0100;
        repeat (3) send_gen("relock");
        chk("relock.locked", 32'(locked), 32'd1);
        do_reset("async_rst");
        repeat (2) step(1'b0, 4'($urandom_range(0, 15)), 1'b0, "post_rst_idle");

        // Gapped stream with garbage during enb low
        g = 4'b0100;
        repeat (3) begin
            step(1'b0, 4'($urandom_range(0, 15)), 1'b0, "gap");
            step(1'b0, 4'($urandom_range(0, 15)), 1'b0, "gap");
            send_gen("gap_sample");
        end
        chk("gap.locked", 32'(locked), 32'd1);

        // Clear on the same cycle as a mismatch
        send_bad(4'b1000, 1'b1, "clr_same");
        chk("clr_same.err", 32'(err), 32'd1);
        chk("clr_same.count", 32'(err_count), 32'd0);
        send_gen("clr_recover");

        // Saturation of the 2-bit counter
        repeat (5) begin
            send_bad(4'b0001, 1'b0, "sat_bad");
            send_gen("sat_good");
        end
        chk("sat.count16", 32'(err_count), 32'd5);
        chk("sat.count2", 32'(err_count_s), 32'd3);
        send_bad(4'b0010, 1'b0, "sat_hold");
        chk("sat_hold.err_s", 32'(err_s), 32'd1);
        chk("sat_hold.count2", 32'(err_count_s), 32'd3);

        // All-zero stream stays unlocked
        do_reset("zero_rst");
        repeat (6) step(1'b1, 4'b0000, 1'b0, "zeros");
        chk("zeros.locked", 32'(locked), 32'd0);

        // Randomized traffic against the model
        g = 4'($urandom_range(1, 15));
        for (int n = 0; n < 800; n++) begin
            int r;
            logic c;
            r = $urandom_range(0, 99);
            c = ($urandom_range(0, 99) < 3);
            if (r < 1) begin
                do_reset("rnd_rst");
            end else if (r < 25) begin
                step(1'b0, 4'($urandom_range(0, 15)), c, "rnd_gap");
            end else if (r < 33) begin
                send_bad(4'($urandom_range(1, 15)), c, "rnd_bad");
            end else if (r < 36) begin
                send_bad(g, c, "rnd_zero");
            end else if (r < 39) begin
                g = 4'($urandom_range(1, 15));
                step(1'b1, g, c, "rnd_seed");
                g = lfsr_next(g);
            end else begin
                step(1'b1, g, c, "rnd_gen");
                g = lfsr_next(g);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
